gcd_job_driver: RTL

Initiator-side controller for the subtracting GCD engine (START/A/B in; Y/DONE/ERROR out). It buffers operand pairs from an upstream valid/ready stream in a small FIFO and issues them to the engine one at a time. It captures each result and hands it downstream on a valid/ready result port. It sits between the host-side operand source and the GCD engine, so neither side has to handle the engine's one-shot handshake.

---
 rtl/gcd_job_driver.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/gcd_job_driver.sv
// Operand FIFO plus one-job-at-a-time issue FSM for the subtracting GCD engine,
// with a single-entry result register. Optional watchdog: GCD_DRV_TIMEOUT_EN.
module gcd_job_driver #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [7:0] IN_A,
  input  logic [7:0] IN_B,
  output logic       G_START,
  output logic [7:0] G_A,
  output logic [7:0] G_B,
  input  logic [7:0] G_Y,
  input  logic       G_DONE,
  input  logic       G_ERROR,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic [7:0] OUT_Y,
  output logic       OUT_ERR,
  output logic       OUT_TIMEOUT,
  output logic       BUSY,
  output logic [7:0] JOB_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [7:0]  TMO_LIMIT = 8'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [15:0] mem_q [DEPTH];
  logic [AW:0] level, level_d;
  logic        in_ready_q;
  logic [7:0]  g_a_q, g_b_q;
  logic        out_valid_q, out_err_q;
  logic [7:0]  out_y_q;
  logic        busy_q;
  logic [7:0]  job_cnt_q;
  logic        push, pop, load_done, load_tmo, tmo_hit;
  logic [15:0] head;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign push    = IN_VALID & in_ready_q;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign level_d = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

`ifdef GCD_DRV_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;
  logic       out_tmo_q;

  // Counter holds the number of WAIT cycles already completed for this job.
  assign tmo_hit     = (tmo_cnt_q + 8'd1) == TMO_LIMIT;
  assign OUT_TIMEOUT = out_tmo_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tmo_cnt_q <= 8'd0;
      out_tmo_q <= 1'b0;
    end else begin
      if (state_q == S_ISSUE)
        tmo_cnt_q <= 8'd0;
      else if (state_q == S_WAIT)
        tmo_cnt_q <= tmo_cnt_q + 8'd1;
      if (load_done)
        out_tmo_q <= 1'b0;
      else if (load_tmo)
        out_tmo_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TMO_LIMIT;
  assign tmo_hit        = 1'b0;
  assign OUT_TIMEOUT    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    load_done = 1'b0;
    load_tmo  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Only issue when the result slot is free or draining this cycle.
        if ((level != '0) && (!out_valid_q || OUT_READY)) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (G_DONE) begin
          load_done = 1'b1;
          state_d   = S_IDLE;
        end else if (tmo_hit) begin
          load_tmo = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge CLK) begin
    if (push)
      mem_q[wr_ptr_q[AW-1:0]] <= {IN_A, IN_B};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      in_ready_q  <= 1'b0;
      g_a_q       <= 8'd0;
      g_b_q       <= 8'd0;
      out_valid_q <= 1'b0;
      out_y_q     <= 8'd0;
      out_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      job_cnt_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (level_d != FULL_LVL);
      busy_q     <= (state_d != S_IDLE) || (level_d != '0);
      if (push)
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
        g_a_q    <= head[15:8];
        g_b_q    <= head[7:0];
      end
      // A reload takes priority over a same-cycle drain.
      if (load_done) begin
        out_valid_q <= 1'b1;
        out_y_q     <= G_Y;
        out_err_q   <= G_ERROR;
      end else if (load_tmo) begin
        out_valid_q <= 1'b1;
        out_y_q     <= 8'd0;
        out_err_q   <= 1'b1;
      end else if (out_valid_q && OUT_READY) begin
        out_valid_q <= 1'b0;
      end
      if (load_done || load_tmo)
        job_cnt_q <= job_cnt_q + 8'd1;
    end
  end

  assign IN_READY  = in_ready_q;
  assign G_START   = (state_q == S_ISSUE);
  assign G_A       = g_a_q;
  assign G_B       = g_b_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_Y     = out_y_q;
  assign OUT_ERR   = out_err_q;
  assign BUSY      = busy_q;
  assign JOB_CNT   = job_cnt_q;

endmodule
